// File: rtl/mix_columns_engine.sv
// mix_columns_engine: handshaked AES MixColumns / InvMixColumns, COLS_PER_CYCLE columns per busy cycle.
// Define MIXCOL_SKIP_EN to add skip_en, which passes the state through unchanged (final round).
//
// state | meaning
// IDLE  | waiting for in_valid; in_ready high
// BUSY  | transforming COLS_PER_CYCLE columns per cycle, ascending column order
// DONE  | result held on state_out until out_ready
module mix_columns_engine #(
    parameter int COLS_PER_CYCLE = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] state_in,
    input  logic         enc_en,
`ifdef MIXCOL_SKIP_EN
    input  logic         skip_en,
`endif
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] state_out,
    output logic         busy
);

    localparam int NUM_PASSES = 4 / COLS_PER_CYCLE;
    localparam logic [1:0] COL_STEP = 2'(COLS_PER_CYCLE);
    localparam logic [1:0] LAST_IDX = 2'((NUM_PASSES - 1) * COLS_PER_CYCLE);

    if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : g_bad_cols
        $error("mix_columns_engine: COLS_PER_CYCLE must be 1, 2 or 4");
    end

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t         state;
    state_t         state_nxt;
    logic [127:0]   work;
    logic [127:0]   work_nxt;
    logic [1:0]     col_idx;
    logic [1:0]     col_sel;
    logic           mode_q;
    logic           skip_q;

    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] mix_column(input logic [31:0] col, input logic enc);
        logic [7:0] a  [4];
        logic [7:0] x2 [4];
        logic [7:0] x4 [4];
        logic [7:0] x8 [4];
        logic [7:0] m9 [4];
        logic [7:0] mb [4];
        logic [7:0] md [4];
        logic [7:0] me [4];
        for (int r = 0; r < 4; r++) begin
            a[r]  = col[24-8*r +: 8];
            x2[r] = xtime(a[r]);
            x4[r] = xtime(x2[r]);
            x8[r] = xtime(x4[r]);
            m9[r] = x8[r] ^ a[r];
            mb[r] = x8[r] ^ x2[r] ^ a[r];
            md[r] = x8[r] ^ x4[r] ^ a[r];
            me[r] = x8[r] ^ x4[r] ^ x2[r];
        end
        // 3a is 2a ^ a; row 0 is the most significant byte of the column
        if (enc)
            return {x2[0] ^ x2[1] ^ a[1] ^ a[2] ^ a[3],
                    a[0] ^ x2[1] ^ x2[2] ^ a[2] ^ a[3],
                    a[0] ^ a[1] ^ x2[2] ^ x2[3] ^ a[3],
                    x2[0] ^ a[0] ^ a[1] ^ a[2] ^ x2[3]};
        else
            return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
                    m9[0] ^ me[1] ^ mb[2] ^ md[3],
                    md[0] ^ m9[1] ^ me[2] ^ mb[3],
                    mb[0] ^ md[1] ^ m9[2] ^ me[3]};
    endfunction

    always_comb begin
        work_nxt = work;
        col_sel  = '0;
        for (int j = 0; j < COLS_PER_CYCLE; j++) begin
            col_sel = col_idx + 2'(j);
            if (!skip_q)
                work_nxt[{col_sel, 5'd0} +: 32] = mix_column(work[{col_sel, 5'd0} +: 32], mode_q);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid)
                    state_nxt = BUSY;
            end
            BUSY: begin
                busy = 1'b1;
                if (col_idx == LAST_IDX)
                    state_nxt = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            work    <= '0;
            mode_q  <= 1'b1;
            col_idx <= '0;
        end else if (state == IDLE && in_valid) begin
            work    <= state_in;
            mode_q  <= enc_en;
            col_idx <= '0;
        end else if (state == BUSY) begin
            work    <= work_nxt;
            col_idx <= col_idx + COL_STEP;
        end
    end

`ifdef MIXCOL_SKIP_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            skip_q <= 1'b0;
        else if (state == IDLE && in_valid)
            skip_q <= skip_en;
    end
`else
    assign skip_q = 1'b0;
`endif

    assign state_out = work;

endmodule

// File: tb/tb_mix_columns_engine.sv
// Bench for mix_columns_engine: three instances (COLS_PER_CYCLE 4/2/1) against a GF(2^8) matrix model.
// Instance d has NUM_PASSES = 1 << d.
module tb_mix_columns_engine;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n;
    logic [2:0]   in_valid;
    logic [2:0]   in_ready;
    logic [2:0]   enc_en;
    logic [2:0]   out_valid;
    logic [2:0]   out_ready;
    logic [2:0]   busy;
    logic [127:0] state_in  [3];
    logic [127:0] state_out [3];
`ifdef MIXCOL_SKIP_EN
    logic [2:0]   skip_en;
`endif

    int errors = 0;
    int checks = 0;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        mix_columns_engine #(.COLS_PER_CYCLE(4 >> g)) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .in_valid  (in_valid[g]),
            .in_ready  (in_ready[g]),
            .state_in  (state_in[g]),
            .enc_en    (enc_en[g]),
`ifdef MIXCOL_SKIP_EN
            .skip_en   (skip_en[g]),
`endif
            .out_valid (out_valid[g]),
            .out_ready (out_ready[g]),
            .state_out (state_out[g]),
            .busy      (busy[g])
        );
    end

    // Reference: carry-less product reduced by polynomial long division modulo 0x11B
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [15:0] p;
        p = '0;
        for (int i = 0; i < 8; i++)
            if (b[i]) p = p ^ (16'(a) << i);
        for (int i = 15; i >= 8; i--)
            if (p[i]) p = p ^ (16'h011b << (i - 8));
        return p[7:0];
    endfunction

    function automatic logic [127:0] mix_ref(input logic [127:0] s, input logic enc);
        logic [7:0]   co [4];
        logic [127:0] r;
        logic [7:0]   acc;
        if (enc) co = '{8'h02, 8'h03, 8'h01, 8'h01};
        else     co = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
        r = '0;
        for (int c = 0; c < 4; c++)
            for (int rr = 0; rr < 4; rr++) begin
                acc = '0;
                for (int k = 0; k < 4; k++)
                    acc = acc ^ gmul(co[(k - rr + 4) % 4], s[c*32 + 24 - 8*k +: 8]);
                r[c*32 + 24 - 8*rr +: 8] = acc;
            end
        return r;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic int np(input int d);
        return 1 << d;
    endfunction

    // Drives one transaction; while waiting, in_valid/enc_en/state_in are scrambled (must be ignored).
    task automatic run_txn(input int d, input logic [127:0] din, input logic enc, input logic skp,
                           output logic [127:0] dout, output int lat, output int busy_cnt,
                           output int ready_hi, output logic acc_ok, output logic ret_ok);
        @(negedge clk);
        in_valid[d] = 1'b1;
        state_in[d] = din;
        enc_en[d]   = enc;
`ifdef MIXCOL_SKIP_EN
        skip_en[d]  = skp;
`endif
        acc_ok = (in_ready[d] === 1'b1);
        @(negedge clk);
        lat = 0;
        busy_cnt = 0;
        ready_hi = 0;
        while (out_valid[d] !== 1'b1 && lat < 20) begin
            if (busy[d] === 1'b1) busy_cnt++;
            if (in_ready[d] !== 1'b0) ready_hi++;
            in_valid[d] = 1'($urandom);
            enc_en[d]   = 1'($urandom);
            state_in[d] = rand128();
`ifdef MIXCOL_SKIP_EN
            skip_en[d]  = 1'($urandom);
`endif
            lat++;
            @(negedge clk);
        end
        dout = state_out[d];
        in_valid[d]  = 1'b0;
        out_ready[d] = 1'b1;
        @(negedge clk);
        out_ready[d] = 1'b0;
        ret_ok = (out_valid[d] === 1'b0 && in_ready[d] === 1'b1);
    endtask

    task automatic test_reset();
        logic seen;
        for (int d = 0; d < 3; d++) begin
            checks++;
            if (in_ready[d] !== 1'b1 || out_valid[d] !== 1'b0 || busy[d] !== 1'b0) begin
                errors++;
                $display("FAIL reset_ctrl dut%0d got rdy=%b ov=%b busy=%b exp 1 0 0",
                         d, in_ready[d], out_valid[d], busy[d]);
            end
            checks++;
            if (state_out[d] !== 128'h0) begin
                errors++;
                $display("FAIL reset_state_out dut%0d got=%h exp=0", d, state_out[d]);
            end
        end
        @(negedge clk);
        in_valid[2] = 1'b1;
        state_in[2] = rand128();
        enc_en[2]   = 1'b1;
        @(negedge clk);
        in_valid[2] = 1'b0;
        @(negedge clk);
        checks++;
        if (busy[2] !== 1'b1) begin
            errors++;
            $display("FAIL reset_pre_busy got=%b exp=1", busy[2]);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid[2] !== 1'b0 || busy[2] !== 1'b0 || state_out[2] !== 128'h0) begin
            errors++;
            $display("FAIL reset_mid_busy got ov=%b busy=%b so=%h exp 0 0 0",
                     out_valid[2], busy[2], state_out[2]);
        end
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (out_valid[2] === 1'b1 || busy[2] === 1'b1) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++;
            $display("FAIL reset_no_output got activity=%b exp=0", seen);
        end
    endtask

    task automatic test_enc_vector();
        logic [127:0] dout;
        logic [127:0] exp_v;
        int lat, bc, rh;
        logic a_ok, r_ok;
        exp_v = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
        run_txn(0, 128'hdb135345_f20a225c_01010101_c6c6c6c6, 1'b1, 1'b0, dout, lat, bc, rh, a_ok, r_ok);
        checks++;
        if (dout !== exp_v) begin
            errors++;
            $display("FAIL enc_vector got=%h exp=%h", dout, exp_v);
        end
        checks++;
        if (lat !== 1 || !a_ok || !r_ok) begin
            errors++;
            $display("FAIL enc_vector_handshake got lat=%0d acc=%b ret=%b exp 1 1 1", lat, a_ok, r_ok);
        end
    endtask

    task automatic test_latency_order();
        logic [127:0] din, dout;
        int lat, bc, rh;
        logic a_ok, r_ok;
        din = rand128();
        din[31:0] = 32'hd4bf5d30;
        run_txn(2, din, 1'b1, 1'b0, dout, lat, bc, rh, a_ok, r_ok);
        checks++;
        if (dout[31:0] !== 32'h046681e5) begin
            errors++;
            $display("FAIL order_col0 got=%h exp=046681e5", dout[31:0]);
        end
        checks++;
        if (dout !== mix_ref(din, 1'b1)) begin
            errors++;
            $display("FAIL order_full got=%h exp=%h", dout, mix_ref(din, 1'b1));
        end
        checks++;
        if (lat !== 4 || bc !== 4) begin
            errors++;
            $display("FAIL latency_cpc1 got lat=%0d busy=%0d exp 4 4", lat, bc);
        end
        checks++;
        if (rh !== 0 || !r_ok) begin
            errors++;
            $display("FAIL ready_during_busy got ready_hi=%0d ret=%b exp 0 1", rh, r_ok);
        end
    endtask

    task automatic test_round_trip(input int n);
        logic [127:0] x, y, z;
        int lat, bc, rh;
        logic a_ok, r_ok;
        for (int d = 0; d < 3; d++) begin
            for (int i = 0; i < n; i++) begin
                x = rand128();
                run_txn(d, x, 1'b1, 1'b0, y, lat, bc, rh, a_ok, r_ok);
                checks++;
                if (y !== mix_ref(x, 1'b1) || lat !== np(d) || bc !== np(d) || !a_ok || !r_ok) begin
                    errors++;
                    $display("FAIL enc_rand dut%0d got=%h lat=%0d exp=%h lat=%0d",
                             d, y, lat, mix_ref(x, 1'b1), np(d));
                end
                run_txn(d, y, 1'b0, 1'b0, z, lat, bc, rh, a_ok, r_ok);
                checks++;
                if (z !== x || lat !== np(d) || !a_ok || !r_ok) begin
                    errors++;
                    $display("FAIL dec_round_trip dut%0d got=%h lat=%0d exp=%h lat=%0d",
                             d, z, lat, x, np(d));
                end
            end
        end
    endtask

    task automatic test_backpressure();
        logic [127:0] x, exp_v;
        int waited;
        logic held_ok;
        x = rand128();
        exp_v = mix_ref(x, 1'b1);
        @(negedge clk);
        in_valid[1] = 1'b1;
        state_in[1] = x;
        enc_en[1]   = 1'b1;
        @(negedge clk);
        in_valid[1] = 1'b0;
        enc_en[1]   = 1'b0;
        waited = 0;
        while (out_valid[1] !== 1'b1 && waited < 20) begin
            enc_en[1] = ~enc_en[1];
            waited++;
            @(negedge clk);
        end
        held_ok = 1'b1;
        for (int i = 0; i < 10; i++) begin
            out_ready[1] = 1'b0;
            in_valid[1]  = 1'b1;
            state_in[1]  = rand128();
            enc_en[1]    = 1'($urandom);
            @(negedge clk);
            if (state_out[1] !== exp_v || in_ready[1] !== 1'b0 || out_valid[1] !== 1'b1) held_ok = 1'b0;
        end
        checks++;
        if (!held_ok || waited !== 2) begin
            errors++;
            $display("FAIL backpressure_hold got so=%h waited=%0d exp=%h waited=2", state_out[1], waited, exp_v);
        end
        out_ready[1] = 1'b1;
        @(negedge clk);
        checks++;
        if (out_valid[1] !== 1'b0 || in_ready[1] !== 1'b1 || busy[1] !== 1'b0) begin
            errors++;
            $display("FAIL backpressure_release got ov=%b rdy=%b busy=%b exp 0 1 0",
                     out_valid[1], in_ready[1], busy[1]);
        end
        in_valid[1]  = 1'b0;
        out_ready[1] = 1'b0;
        @(negedge clk);
    endtask

`ifdef MIXCOL_SKIP_EN
    task automatic test_skip();
        logic [127:0] x, dout;
        int lat, bc, rh;
        logic a_ok, r_ok;
        x = 128'h00112233_44556677_8899aabb_ccddeeff;
        for (int d = 0; d < 3; d++) begin
            run_txn(d, x, 1'($urandom), 1'b1, dout, lat, bc, rh, a_ok, r_ok);
            checks++;
            if (dout !== x || lat !== np(d) || !r_ok) begin
                errors++;
                $display("FAIL skip dut%0d got=%h lat=%0d exp=%h lat=%0d", d, dout, lat, x, np(d));
            end
        end
    endtask
`endif

    initial begin
        rst_n     = 1'b0;
        in_valid  = '0;
        enc_en    = '1;
        out_ready = '0;
        for (int d = 0; d < 3; d++) state_in[d] = '0;
`ifdef MIXCOL_SKIP_EN
        skip_en   = '0;
`endif
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        test_reset();
        test_enc_vector();
        test_latency_order();
        test_backpressure();
`ifdef MIXCOL_SKIP_EN
        test_skip();
`endif
        test_round_trip(1000);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
